// File: rtl/cue_seq_pkg.sv
// rtl/cue_seq_pkg.sv - shared lane/state types for the cue sequencer
package cue_seq_pkg;
  localparam int NUM_LANES = 4;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t PLAY = 2'd1;
  localparam state_t DONE = 2'd2;

  typedef logic [NUM_LANES-1:0] lane_mask_t;
endpackage

// File: rtl/beat_timer.sv
// rtl/beat_timer.sv - modulo-BEAT_DIV beat counter with clear/enable and one-cycle wrap strobe
module beat_timer #(
  parameter int BEAT_DIV = 25000000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic wrap
);
  localparam int CW = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;

  logic [CW-1:0] cnt;

  assign wrap = en && (cnt == CW'(BEAT_DIV - 1));

  always_ff @(posedge CLOCK_50) begin
    if (reset || clr) cnt <= '0;
    else if (en)      cnt <= wrap ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/cue_sequencer.sv
// rtl/cue_sequencer.sv - plays a stored 4-lane cue pattern at a fixed beat rate
// Optional pause input enabled by CUE_SEQUENCER_PAUSE_EN.
module cue_sequencer
  import cue_seq_pkg::*;
#(
  parameter int BEAT_DIV      = 25000000,
  parameter int WINDOW_CYCLES = 5000000,
  parameter int DEPTH         = 64,
  parameter int CNT_W         = 16,
  localparam int ADDR_W       = $clog2(DEPTH)
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
`ifdef CUE_SEQUENCER_PAUSE_EN
  input  logic                   pause,
`endif
  input  logic                   start,
  input  logic                   stop,
  input  logic                   loop,
  input  logic                   pat_we,
  input  logic [ADDR_W-1:0]      pat_addr,
  input  logic [3:0]             pat_data,
  input  logic [ADDR_W:0]        pat_len,
  output logic [3:0]             cue_pulse,
  output logic [3:0]             cue_window,
  output logic [ADDR_W-1:0]      step_idx,
  output logic                   busy,
  output logic                   done,
  output logic [4*CNT_W-1:0]     cue_count
);
  localparam int TW = $clog2(WINDOW_CYCLES + 1);

  state_t            state, state_n;
  lane_mask_t        mem [DEPTH];
  logic [ADDR_W-1:0] step;
  logic [ADDR_W:0]   len_q;
  lane_mask_t        pulse_q;
  lane_mask_t        emit_mask;
  logic              hold;
  logic              wrap;
  logic              last_step;
  logic              emit;
  logic [ADDR_W-1:0] emit_idx;
  logic              kill;

`ifdef CUE_SEQUENCER_PAUSE_EN
  assign hold = pause && (state == PLAY);
`else
  assign hold = 1'b0;
`endif

  beat_timer #(.BEAT_DIV(BEAT_DIV)) u_beat (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .clr      (state != PLAY),
    .en       ((state == PLAY) && !hold),
    .wrap     (wrap)
  );

  assign last_step = ({1'b0, step} == (len_q - 1'b1));
  assign kill      = stop && (state == PLAY);

  always_comb begin
    state_n  = state;
    emit     = 1'b0;
    emit_idx = step;
    case (state)
      IDLE, DONE: begin
        if (stop) state_n = IDLE;
        else if (start) begin
          if (pat_len == '0) state_n = DONE;
          else begin
            state_n  = PLAY;
            emit     = 1'b1;
            emit_idx = '0;
          end
        end
      end
      PLAY: begin
        if (stop) state_n = IDLE;
        else if (wrap) begin
          if (!last_step) begin
            emit     = 1'b1;
            emit_idx = step + 1'b1;
          end else if (loop) begin
            emit     = 1'b1;
            emit_idx = '0;
          end else begin
            state_n = DONE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign emit_mask = emit ? mem[emit_idx] : '0;

  // Pattern RAM survives reset so a loaded chart can be replayed.
  always_ff @(posedge CLOCK_50) begin
    if (pat_we && (state != PLAY)) mem[pat_addr] <= pat_data;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state   <= IDLE;
      step    <= '0;
      len_q   <= '0;
      pulse_q <= '0;
    end else begin
      state <= state_n;
      if ((state != PLAY) && start && !stop) len_q <= pat_len;
      if (emit) step <= emit_idx;
      if (kill)       pulse_q <= '0;
      else if (!hold) pulse_q <= emit_mask;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [TW-1:0]    timer;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLOCK_50) begin
      if (reset) begin
        timer <= '0;
        cnt   <= '0;
      end else if (kill) begin
        timer <= '0;
      end else if (emit_mask[i]) begin
        timer <= TW'(WINDOW_CYCLES);
        cnt   <= cnt + 1'b1;
      end else if (!hold && (timer != '0)) begin
        timer <= timer - 1'b1;
      end
    end

    assign cue_window[i]               = (timer != '0);
    assign cue_count[i*CNT_W +: CNT_W] = cnt;
  end

  assign cue_pulse = pulse_q & {4{!hold}};
  assign step_idx  = step;
  assign busy      = (state == PLAY);
  assign done      = (state == DONE);
endmodule

// File: tb/tb_cue_sequencer.sv
// tb/tb_cue_sequencer.sv - scoreboard bench for cue_sequencer with an event-list reference model
module tb_cue_sequencer;
  localparam int B   = 4;
  localparam int W   = 2;
  localparam int D   = 8;
  localparam int CW  = 10;
  localparam int AW  = 3;
  localparam int BIG = 32'h7fffffff;

  logic          CLOCK_50 = 1'b0;
  logic          reset    = 1'b1;
  logic          start    = 1'b0;
  logic          stop     = 1'b0;
  logic          loop     = 1'b0;
  logic          pat_we   = 1'b0;
  logic [AW-1:0] pat_addr = '0;
  logic [3:0]    pat_data = '0;
  logic [AW:0]   pat_len  = '0;
  logic [3:0]    cue_pulse, cue_window;
  logic [AW-1:0] step_idx;
  logic          busy, done;
  logic [4*CW-1:0] cue_count;
`ifdef CUE_SEQUENCER_PAUSE_EN
  logic          pause = 1'b0;
`endif

  cue_sequencer #(.BEAT_DIV(B), .WINDOW_CYCLES(W), .DEPTH(D), .CNT_W(CW)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
`ifdef CUE_SEQUENCER_PAUSE_EN
    .pause      (pause),
`endif
    .start      (start),
    .stop       (stop),
    .loop       (loop),
    .pat_we     (pat_we),
    .pat_addr   (pat_addr),
    .pat_data   (pat_data),
    .pat_len    (pat_len),
    .cue_pulse  (cue_pulse),
    .cue_window (cue_window),
    .step_idx   (step_idx),
    .busy       (busy),
    .done       (done),
    .cue_count  (cue_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [3:0] m;
    int         idx;
  } ev_t;

  ev_t        exp_q[$];
  logic [3:0] mem_m [D];
  int         cnt_m [4];
  int         last_idx_m = 0;
  int         win_last [4];
  int         win_kill [4];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops expected cues whenever the DUT pulses, checks windows every cycle.
  always @(negedge CLOCK_50) begin
    ev_t        e;
    logic [3:0] ew;
    while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
      e = exp_q.pop_front();
      chk("missed_pulse_at", -1, e.c);
    end
    if (cue_pulse !== 4'b0) begin
      if (exp_q.size() == 0) chk("unexpected_pulse", cue_pulse, 0);
      else begin
        e = exp_q.pop_front();
        chk("pulse_cycle", cyc, e.c);
        chk("pulse_mask", cue_pulse, e.m);
        chk("pulse_step", step_idx, e.idx);
        for (int i = 0; i < 4; i++) begin
          if (e.m[i]) begin
            win_last[i] = e.c;
            if (e.c >= win_kill[i]) win_kill[i] = BIG;
          end
        end
      end
    end
    for (int i = 0; i < 4; i++)
      ew[i] = (cyc >= win_last[i]) && (cyc < win_last[i] + W) && (cyc < win_kill[i]);
    chk("cue_window", cue_window, ew);
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic wr(int a, logic [3:0] d);
    pat_we   = 1'b1;
    pat_addr = AW'(a);
    pat_data = d;
    mem_m[a] = d;
    tick();
    pat_we = 1'b0;
  endtask

  task automatic check_counts(string tag);
    for (int i = 0; i < 4; i++) chk({tag, "_count"}, cue_count[i*CW +: CW], cnt_m[i]);
  endtask

  task automatic to_idle();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  // len steps, lp loop, stop_at / rst_at relative to the start cycle (-1 = none)
  task automatic run(int len, bit lp, int stop_at, int rst_at);
    int s, n, c, endc, k;
    ev_t e;
    pat_len = AW'(0);
    pat_len = len[AW:0];
    loop    = lp;
    start   = 1'b1;
    s       = cyc;
    n       = 0;
    if (len > 0) begin
      while (n < 100000) begin
        c = s + 1 + n * B;
        if (!lp && n >= len) break;
        if (stop_at >= 0 && c > s + stop_at) break;
        if (rst_at >= 0 && c > s + rst_at) break;
        k = n % len;
        if (mem_m[k] != 4'b0) begin
          e.c = c; e.m = mem_m[k]; e.idx = k;
          exp_q.push_back(e);
          for (int i = 0; i < 4; i++) cnt_m[i] = (cnt_m[i] + int'(mem_m[k][i])) % (1 << CW);
        end
        last_idx_m = k;
        n++;
      end
    end
    if (stop_at >= 0)      endc = s + stop_at;
    else if (rst_at >= 0)  endc = s + rst_at;
    else                   endc = s + len * B;
    if (len == 0)          endc = s;
    tick();
    start = 1'b0;
    while (cyc <= endc) begin
      if (cyc == s + stop_at) begin
        stop = 1'b1;
        for (int i = 0; i < 4; i++) win_kill[i] = cyc + 1;
      end
      if (cyc == s + rst_at) begin
        reset = 1'b1;
        for (int i = 0; i < 4; i++) win_kill[i] = cyc + 1;
      end
      if ($urandom_range(0, 3) == 0) begin
        pat_we   = 1'b1;
        pat_addr = AW'($urandom_range(0, D - 1));
        pat_data = 4'($urandom_range(0, 15));
      end
      chk("busy_in_play", busy, 1);
      tick();
      stop   = 1'b0;
      reset  = 1'b0;
      pat_we = 1'b0;
    end
    if (rst_at >= 0 && len > 0) begin
      for (int i = 0; i < 4; i++) cnt_m[i] = 0;
      last_idx_m = 0;
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_pulse", cue_pulse, 0);
    end else if (stop_at >= 0 && len > 0) begin
      chk("stop_busy", busy, 0);
      chk("stop_done", done, 0);
    end else begin
      chk("end_done", done, 1);
      chk("end_busy", busy, 0);
    end
    chk("step_idx_hold", step_idx, last_idx_m);
    check_counts("run");
  endtask

  initial begin
    int len, st, rs, nreq;
    bit lp;
    for (int i = 0; i < 4; i++) begin
      cnt_m[i]    = 0;
      win_last[i] = -1000;
      win_kill[i] = BIG;
    end
    for (int i = 0; i < D; i++) mem_m[i] = 4'b0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_step", step_idx, 0);
    chk("rst_pulse", cue_pulse, 0);
    check_counts("rst");
    reset = 1'b0;

    for (int i = 0; i < D; i++) wr(i, 4'b0);
    wr(0, 4'd1); wr(1, 4'd2); wr(2, 4'd4); wr(3, 4'd8);
    while (cyc < 10) tick();
    run(4, 1'b0, -1, -1);
    run(4, 1'b1, 40, -1);

    to_idle();
    wr(0, 4'd3); wr(1, 4'd0); wr(2, 4'd3);
    run(3, 1'b0, -1, -1);

    wr(0, 4'd1); wr(1, 4'd2); wr(2, 4'd4); wr(3, 4'd8);
    run(4, 1'b0, 6, -1);
    wr(4, 4'd5);
    run(5, 1'b0, -1, -1);

    run(0, 1'b0, -1, -1);
    to_idle();
    wr(0, 4'd1);
    nreq = (((1 << CW) - 1 - cnt_m[0]) % (1 << CW) + (1 << CW)) % (1 << CW);
    if (nreq > 0) run(1, 1'b1, (nreq - 1) * B + 1, -1);
    chk("lane0_at_max", cue_count[CW-1:0], (1 << CW) - 1);
    run(1, 1'b0, -1, -1);
    chk("lane0_wrapped", cue_count[CW-1:0], 0);

    wr(0, 4'd1); wr(1, 4'd2); wr(2, 4'd4); wr(3, 4'd8);
    run(4, 1'b1, -1, 3);
    check_counts("after_reset");
    run(4, 1'b0, -1, -1);

    repeat (24) begin
      if ($urandom_range(0, 1) == 1) to_idle();
      repeat ($urandom_range(0, 4)) wr($urandom_range(0, D - 1), 4'($urandom_range(0, 15)));
      len = $urandom_range(0, D);
      lp  = 1'($urandom_range(0, 1));
      st  = -1;
      rs  = -1;
      if (len > 0) begin
        if ($urandom_range(0, 7) == 0) rs = $urandom_range(1, len * B * 2);
        else if (lp) st = $urandom_range(1, len * B * 2 + 3);
        else if ($urandom_range(0, 1) == 1) st = $urandom_range(1, len * B);
      end
      run(len, lp, st, rs);
    end

    repeat (6) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
